ifmap_status_ring: RTL and testbench

Parametrised status tracker for the IFMap scratchpad, organised as a circular buffer of window tags. Supports any depth (not only powers of two) with true wrap-around. Adds write/release handshakes, a multi-cycle window-release state machine, and occupancy/window counters. Sits between the IFMap write counter, the read address generator and the controller that retires consumed input windows.

---
 rtl/ifmap_status_ring_if.sv | 34 +++
 rtl/ifmap_status_ring.sv | 93 +++++++++
 tb/tb_ifmap_status_ring.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/ifmap_status_ring_if.sv
// rtl/ifmap_status_ring_if.sv - write/release/read bundle for the IFMap status ring
interface ifmap_status_ring_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int CNT_WIDTH  = 5
);
    logic                  wr_valid;
    logic [1:0]            wr_tag;
    logic                  wr_ready;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic                  rel_valid;
    logic                  rel_ready;
    logic [ADDR_WIDTH-1:0] head_ptr;
    logic [1:0]            head_status;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [1:0]            rd_status;
    logic                  rd_empty;
    logic [CNT_WIDTH-1:0]  occupancy;
    logic [CNT_WIDTH-1:0]  win_count;
    logic                  empty;
    logic                  full;
    logic                  err;

    modport master (
        output wr_valid, wr_tag, rel_valid, rd_addr,
        input  wr_ready, wr_ptr, rel_ready, head_ptr, head_status,
               rd_status, rd_empty, occupancy, win_count, empty, full, err
    );

    modport slave (
        input  wr_valid, wr_tag, rel_valid, rd_addr,
        output wr_ready, wr_ptr, rel_ready, head_ptr, head_status,
               rd_status, rd_empty, occupancy, win_count, empty, full, err
    );
endinterface

// File: rtl/ifmap_status_ring.sv
// rtl/ifmap_status_ring.sv - circular window-tag tracker for the IFMap scratchpad
module ifmap_status_ring #(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int CNT_WIDTH  = $clog2(DEPTH+1)
) (
    input  logic                clk,
    input  logic                rst_n,
    ifmap_status_ring_if.slave  bus
);
    localparam logic [1:0] TAG_EMPTY = 2'b00;
    localparam logic [1:0] TAG_END   = 2'b10;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [CNT_WIDTH-1:0]  DEPTH_C  = CNT_WIDTH'(DEPTH);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                state_q, state_d;
    logic [1:0]            mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, head_ptr_q;
    logic [CNT_WIDTH-1:0]  occ_q, win_q;
    logic                  err_q;

    logic       wr_ready_i, rel_ready_i;
    logic       wr_fire, rel_fire, clr_en, clr_end, err_set;
    logic [1:0] head_tag;

    // Wrap by compare so non-power-of-two depths never visit unused indices.
    function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    assign head_tag   = mem[head_ptr_q];
    assign wr_ready_i = (mem[wr_ptr_q] == TAG_EMPTY);

    always_comb begin
        state_d     = state_q;
        rel_ready_i = (state_q == IDLE) && (win_q != '0);
        wr_fire     = bus.wr_valid && wr_ready_i && (bus.wr_tag != TAG_EMPTY);
        rel_fire    = bus.rel_valid && rel_ready_i;
        clr_en      = rel_fire || (state_q == CLEAR);
        clr_end     = clr_en && (head_tag == TAG_END);
        err_set     = (bus.wr_valid && (bus.wr_tag == TAG_EMPTY)) ||
                      (bus.rel_valid && (state_q == IDLE) && (win_q == '0));
        case (state_q)
            IDLE:    if (rel_fire && !clr_end) state_d = CLEAR;
            CLEAR:   if (clr_end)              state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= TAG_EMPTY;
        end else begin
            // Write slot is always EMPTY and the clear slot always occupied, so they never alias.
            if (clr_en)  mem[head_ptr_q] <= TAG_EMPTY;
            if (wr_fire) mem[wr_ptr_q]   <= bus.wr_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            head_ptr_q <= '0;
            occ_q      <= '0;
            win_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (wr_fire) wr_ptr_q   <= next_ptr(wr_ptr_q);
            if (clr_en)  head_ptr_q <= next_ptr(head_ptr_q);
            occ_q <= occ_q + CNT_WIDTH'(wr_fire) - CNT_WIDTH'(clr_en);
            win_q <= win_q + CNT_WIDTH'(wr_fire && (bus.wr_tag == TAG_END)) - CNT_WIDTH'(clr_end);
            if (err_set) err_q <= 1'b1;
        end
    end

    assign bus.wr_ready    = wr_ready_i;
    assign bus.wr_ptr      = wr_ptr_q;
    assign bus.rel_ready   = rel_ready_i;
    assign bus.head_ptr    = head_ptr_q;
    assign bus.head_status = head_tag;
    assign bus.rd_status   = ({1'b0, bus.rd_addr} < DEPTH_W) ? mem[bus.rd_addr] : TAG_EMPTY;
    assign bus.rd_empty    = (bus.rd_status == TAG_EMPTY);
    assign bus.occupancy   = occ_q;
    assign bus.win_count   = win_q;
    assign bus.empty       = (occ_q == '0);
    assign bus.full        = (occ_q == DEPTH_C);
    assign bus.err         = err_q;
endmodule

// File: tb/tb_ifmap_status_ring.sv
// tb/tb_ifmap_status_ring.sv - self-checking bench for ifmap_status_ring
module tb_ifmap_status_ring;
    localparam int D = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ifmap_status_ring_if #(.ADDR_WIDTH(3), .CNT_WIDTH(3)) bus();
    ifmap_status_ring #(.DEPTH(D), .ADDR_WIDTH(3), .CNT_WIDTH(3)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: ordered list of live tags starting at m_head, plus clears still owed.
    int q[$];
    int m_head = 0;
    int m_pend = 0;
    bit m_err = 0;

    typedef struct {
        bit wv; int tg; bit rv;
        int occ; int wc; int wp; int hp; bit rr;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int m_ends();
        int n = 0;
        foreach (q[i]) if (q[i] == 2) n++;
        return n;
    endfunction

    function automatic int m_tag_at(input int a);
        foreach (q[i]) if ((m_head + i) % D == a) return q[i];
        return 0;
    endfunction

    task automatic model_reset();
        q.delete(); m_head = 0; m_pend = 0; m_err = 0;
    endtask

    task automatic model_edge(input bit wv, input int tg, input bit rv);
        bit rr, wrdy;
        int len, t;
        rr   = (m_pend == 0) && (m_ends() != 0);
        wrdy = q.size() < D;
        if (wv && tg == 0) m_err = 1;
        if (rv && m_pend == 0 && m_ends() == 0) m_err = 1;
        if (m_pend > 0) begin
            t = q.pop_front(); m_head = (m_head + 1) % D; m_pend--;
        end else if (rv && rr) begin
            len = 0;
            for (int i = q.size() - 1; i >= 0; i--) if (q[i] == 2) len = i + 1;
            t = q.pop_front(); m_head = (m_head + 1) % D; m_pend = len - 1;
        end
        if (wv && tg != 0 && wrdy) q.push_back(tg);
    endtask

    task automatic check_model();
        int occ;
        occ = q.size();
        chk("wr_ptr", bus.wr_ptr, (m_head + occ) % D);
        chk("head_ptr", bus.head_ptr, m_head);
        chk("occupancy", bus.occupancy, occ);
        chk("win_count", bus.win_count, m_ends());
        chk("wr_ready", bus.wr_ready, int'(occ < D));
        chk("rel_ready", bus.rel_ready, int'(m_pend == 0 && m_ends() != 0));
        chk("empty", bus.empty, int'(occ == 0));
        chk("full", bus.full, int'(occ == D));
        chk("head_status", bus.head_status, m_tag_at(m_head));
        chk("rd_status", bus.rd_status, m_tag_at(int'(bus.rd_addr)));
        chk("rd_empty", bus.rd_empty, int'(m_tag_at(int'(bus.rd_addr)) == 0));
        chk("err", bus.err, int'(m_err));
    endtask

    // Called #1 after an edge; returns #1 after the next edge with everything checked.
    task automatic cycle(input bit wv, input int tg, input bit rv, input int ra);
        bus.wr_valid = wv; bus.wr_tag = tg[1:0]; bus.rel_valid = rv; bus.rd_addr = ra[2:0];
        @(posedge clk);
        model_edge(wv, tg, rv);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        bus.wr_valid = 0; bus.wr_tag = 0; bus.rel_valid = 0; bus.rd_addr = 0;
        rst_n = 0;
        model_reset();
        #1;
        check_model();
        for (int a = 0; a < D; a++) begin
            bus.rd_addr = a[2:0];
            #1;
            chk("reset_rd_status", bus.rd_status, 0);
        end
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    initial begin
        tbl[0]  = '{1, 1, 0, 1, 0, 1, 0, 0};
        tbl[1]  = '{1, 3, 0, 2, 0, 2, 0, 0};
        tbl[2]  = '{1, 2, 0, 3, 1, 3, 0, 1};
        tbl[3]  = '{1, 1, 0, 4, 1, 4, 0, 1};
        tbl[4]  = '{1, 3, 0, 5, 1, 5, 0, 1};
        tbl[5]  = '{1, 2, 0, 6, 2, 0, 0, 1};
        tbl[6]  = '{1, 1, 0, 6, 2, 0, 0, 1};
        tbl[7]  = '{0, 0, 1, 5, 2, 0, 1, 0};
        tbl[8]  = '{0, 0, 0, 4, 2, 0, 2, 0};
        tbl[9]  = '{0, 0, 0, 3, 1, 0, 3, 1};
        tbl[10] = '{1, 1, 0, 4, 1, 1, 3, 1};
        tbl[11] = '{1, 2, 0, 5, 2, 2, 3, 1};

        bus.wr_valid = 0; bus.wr_tag = 0; bus.rel_valid = 0; bus.rd_addr = 0;
        #1;
        do_reset();

        // Fill, full-stall, 3-entry release and wrap-around
        foreach (tbl[i]) begin
            cycle(tbl[i].wv, tbl[i].tg, tbl[i].rv, i % D);
            chk("tbl_occ", bus.occupancy, tbl[i].occ);
            chk("tbl_win", bus.win_count, tbl[i].wc);
            chk("tbl_wr_ptr", bus.wr_ptr, tbl[i].wp);
            chk("tbl_head", bus.head_ptr, tbl[i].hp);
            chk("tbl_rel_ready", bus.rel_ready, tbl[i].rr);
            chk("tbl_full", bus.full, int'(tbl[i].occ == D));
        end

        // Async reset in the middle of a CLEAR
        do_reset();
        cycle(1, 1, 0, 0); cycle(1, 3, 0, 1); cycle(1, 3, 0, 2); cycle(1, 2, 0, 3);
        cycle(0, 0, 1, 0);
        rst_n = 0;
        #1;
        chk("mid_rst_occ", bus.occupancy, 0);
        chk("mid_rst_wr_ptr", bus.wr_ptr, 0);
        chk("mid_rst_empty", bus.empty, 1);
        chk("mid_rst_rel_ready", bus.rel_ready, 0);
        chk("mid_rst_err", bus.err, 0);
        do_reset();
        cycle(1, 1, 0, 0);
        chk("post_rst_write", bus.occupancy, 1);

        // Writes overlapping a 4-entry CLEAR
        do_reset();
        cycle(1, 1, 0, 0); cycle(1, 3, 0, 1); cycle(1, 3, 0, 2); cycle(1, 2, 0, 3);
        cycle(1, 1, 1, 4); chk("ovl_occ0", bus.occupancy, 4); chk("ovl_wc0", bus.win_count, 1);
        cycle(1, 3, 0, 5); chk("ovl_occ1", bus.occupancy, 4); chk("ovl_wc1", bus.win_count, 1);
        cycle(1, 3, 0, 0); chk("ovl_occ2", bus.occupancy, 4); chk("ovl_wc2", bus.win_count, 1);
        cycle(1, 3, 0, 1); chk("ovl_occ3", bus.occupancy, 4); chk("ovl_wc3", bus.win_count, 0);

        // rel_valid held across windows of length 3 and 1, then a release with none queued
        do_reset();
        cycle(1, 1, 0, 0); cycle(1, 3, 0, 0); cycle(1, 2, 0, 0); cycle(1, 2, 0, 0);
        cycle(0, 0, 1, 0); chk("hs_rr_e0", bus.rel_ready, 0);
        cycle(0, 0, 1, 0); chk("hs_rr_e1", bus.rel_ready, 0);
        cycle(0, 0, 1, 0); chk("hs_rr_e2", bus.rel_ready, 1);
        cycle(0, 0, 1, 0); chk("hs_wc_e3", bus.win_count, 0); chk("hs_empty_e3", bus.empty, 1);
        chk("hs_err_before", bus.err, 0);
        cycle(0, 0, 1, 0); chk("hs_err_after", bus.err, 1); chk("hs_head", bus.head_ptr, 4);

        // Illegal tag write
        do_reset();
        cycle(1, 0, 0, 0); chk("bad_tag_err", bus.err, 1); chk("bad_tag_wp", bus.wr_ptr, 0);

        // Length-1 windows retired back to back
        do_reset();
        cycle(1, 2, 0, 0); cycle(1, 2, 0, 1); cycle(1, 2, 0, 2);
        for (int i = 1; i <= 3; i++) begin
            cycle(0, 0, 1, 0);
            chk("len1_head", bus.head_ptr, i);
            chk("len1_wc", bus.win_count, 3 - i);
        end

        // Random traffic against the reference
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            int tg;
            tg = ($urandom_range(0, 99) == 0) ? 0 : $urandom_range(1, 3);
            if ($urandom_range(0, 599) == 0) do_reset();
            cycle($urandom_range(0, 2) != 0, tg, $urandom_range(0, 1), $urandom_range(0, D - 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
